// File: rtl/divu_pkg.sv
// Shared types and constants for the iterative unsigned divider.
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divu_state_e;

    localparam int          DIVU_ITER     = 32;
    localparam int          DIVU_CNT_W    = 5;
    localparam logic [31:0] DIVU_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry in/out; used as a trial subtractor (a + ~b + 1).
module full_adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_carry,
    output logic [31:0] o_sum,
    output logic        o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_carry};

endmodule

// File: rtl/divu_seq_32bit.sv
// Restoring unsigned 32-bit divider, one quotient bit per cycle, valid/ready on both sides.
module divu_seq_32bit
    import divu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit ZERO_FAST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_div_by_zero,
    output logic              o_busy
);

    if (DATA_W != 32) begin : g_bad_width
        $error("divu_seq_32bit supports DATA_W=32 only");
    end

    divu_state_e             state_q;
    logic [DIVU_CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]       quo_q;
    logic [DATA_W-1:0]       rem_q;
    logic [DATA_W-1:0]       div_q;
    logic                    dbz_q;
    logic                    ready_q;
    logic                    valid_q;
    logic                    busy_q;

    logic [DATA_W:0]         shifted;
    logic [DATA_W-1:0]       divisor_n;
    logic [DATA_W-1:0]       sub_sum;
    logic                    sub_carry;
    logic                    ge;

    // Bring the next dividend bit into the partial remainder; bit 32 set means it
    // already exceeds any 32-bit divisor.
    assign shifted   = {rem_q, quo_q[DATA_W-1]};
    assign divisor_n = ~div_q;

    full_adder_32bit u_trial_sub (
        .i_a     (shifted[DATA_W-1:0]),
        .i_b     (divisor_n),
        .i_carry (1'b1),
        .o_sum   (sub_sum),
        .o_carry (sub_carry)
    );

    assign ge = shifted[DATA_W] | sub_carry;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (i_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && ready_q) begin
                        div_q   <= i_divisor;
                        cnt_q   <= '0;
                        dbz_q   <= (i_divisor == '0);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if ((i_divisor == '0) && ZERO_FAST) begin
                            quo_q   <= DIVU_ALL_ONES;
                            rem_q   <= i_dividend;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q   <= i_dividend;
                            rem_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= ge ? sub_sum : shifted[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == DIVU_CNT_W'(DIVU_ITER - 1)) begin
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = ready_q;
    assign o_valid       = valid_q;
    assign o_busy        = busy_q;
    assign o_quotient    = quo_q;
    assign o_remainder   = rem_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu_seq_32bit.sv
// Randomized and directed checks of divu_seq_32bit against a plain-arithmetic division model.
module tb_divu_seq_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        cons_ready;
    logic        sel;
    logic [31:0] dividend;
    logic [31:0] divisor;

    wire         valid0, valid1, rdy_in0, rdy_in1;
    wire         ov0, ov1, ordy0, ordy1, obusy0, obusy1, odbz0, odbz1;
    wire  [31:0] oq0, oq1, or0, or1;
    wire         cur_valid, cur_ready, cur_busy, cur_dbz;
    wire  [31:0] cur_q, cur_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0 takes the zero-divisor shortcut, instance 1 iterates for it.
    assign valid0  = req_valid & ~sel;
    assign valid1  = req_valid & sel;
    assign rdy_in0 = sel ? 1'b1 : cons_ready;
    assign rdy_in1 = sel ? cons_ready : 1'b1;

    assign cur_valid = sel ? ov1    : ov0;
    assign cur_ready = sel ? ordy1  : ordy0;
    assign cur_busy  = sel ? obusy1 : obusy0;
    assign cur_dbz   = sel ? odbz1  : odbz0;
    assign cur_q     = sel ? oq1    : oq0;
    assign cur_r     = sel ? or1    : or0;

    divu_seq_32bit #(.DATA_W(32), .ZERO_FAST(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_valid(valid0), .o_ready(ordy0),
        .i_dividend(dividend), .i_divisor(divisor),
        .o_valid(ov0), .i_ready(rdy_in0),
        .o_quotient(oq0), .o_remainder(or0),
        .o_div_by_zero(odbz0), .o_busy(obusy0)
    );

    divu_seq_32bit #(.DATA_W(32), .ZERO_FAST(1'b0)) dut_nz (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_valid(valid1), .o_ready(ordy1),
        .i_dividend(dividend), .i_divisor(divisor),
        .o_valid(ov1), .i_ready(rdy_in1),
        .o_quotient(oq1), .o_remainder(or1),
        .o_div_by_zero(odbz1), .o_busy(obusy1)
    );

    // Reference: RV32M DIVU/REMU semantics.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dbz);
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dbz = 1'b1;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
        end
    endfunction

    // Entered and left on a falling edge; accepts one request and waits for its result.
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic hold, input string name);
        logic [31:0] eq, er;
        logic        edbz;
        int          exp_lat;
        int          n;
        ref_div(a, b, eq, er, edbz);
        exp_lat = (b == 32'd0 && s == 1'b0) ? 0 : 32;
        sel        = s;
        dividend   = a;
        divisor    = b;
        req_valid  = 1'b1;
        cons_ready = ~hold;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        n = 0;
        @(negedge clk);
        while (!cur_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s timeout: no o_valid within 100 cycles", name);
        end else begin
            checks++;
            if (n !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
            end
        end
        checks++;
        if (cur_q !== eq || cur_r !== er || cur_dbz !== edbz) begin
            errors++;
            $display("FAIL %s result: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                     name, cur_q, cur_r, cur_dbz, eq, er, edbz);
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checks++;
                if (cur_valid !== 1'b1 || cur_ready !== 1'b0 || cur_q !== eq || cur_r !== er) begin
                    errors++;
                    $display("FAIL %s hold%0d: got v=%b rdy=%b q=%h r=%h expected v=1 rdy=0 q=%h r=%h",
                             name, i, cur_valid, cur_ready, cur_q, cur_r, eq, er);
                end
            end
            cons_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (cur_valid !== 1'b0 || cur_ready !== 1'b1 || cur_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got v=%b rdy=%b busy=%b expected v=0 rdy=1 busy=0",
                     name, cur_valid, cur_ready, cur_busy);
        end
        @(negedge clk);
        $display("op %s s=%0d %h/%h -> q=%h r=%h lat=%0d", name, s, a, b, eq, er, n);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (ordy0 !== 1'b1 || ov0 !== 1'b0 || obusy0 !== 1'b0 || oq0 !== 32'd0 ||
            or0 !== 32'd0 || odbz0 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdy=%b v=%b busy=%b q=%h r=%h dbz=%b expected 1 0 0 0 0 0",
                     name, ordy0, ov0, obusy0, oq0, or0, odbz0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; cons_ready = 1'b1; sel = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_state");
        checks++;
        if (ordy1 !== 1'b1 || ov1 !== 1'b0 || obusy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state_nz: got rdy=%b v=%b busy=%b expected 1 0 0", ordy1, ov1, obusy1);
        end
        $display("reset done");
    endtask

    task automatic test_directed();
        run_op(1'b0, 32'd100, 32'd7, 1'b0, "100div7");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "max_div1");
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "max_div_big");
        run_op(1'b0, 32'h0000_1234, 32'd0, 1'b0, "div0_fast");
        run_op(1'b1, 32'h0000_1234, 32'd0, 1'b0, "div0_iter");
        run_op(1'b1, 32'd100, 32'd7, 1'b0, "100div7_nz");
    endtask

    task automatic test_backpressure();
        run_op(1'b0, 32'd5, 32'd9, 1'b1, "bp_5div9");
    endtask

    task automatic test_flush();
        int seen;
        sel = 1'b0; dividend = 32'd1000; divisor = 32'd3; req_valid = 1'b1; cons_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(posedge clk);
        #1;
        checks++;
        if (ov0 !== 1'b0 || ordy0 !== 1'b1 || obusy0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: got v=%b rdy=%b busy=%b expected 0 1 0", ov0, ordy0, obusy0);
        end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov0 || obusy0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_result: got %0d active cycles expected 0", seen);
        end
        $display("flush done");
        run_op(1'b0, 32'd50, 32'd5, 1'b0, "after_flush_50div5");
    endtask

    task automatic test_async_reset();
        int seen;
        sel = 1'b0; dividend = 32'd777; divisor = 32'd13; req_valid = 1'b1; cons_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset_mid_calc");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset_release");
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_result: got %0d valid cycles expected 0", seen);
        end
        $display("async reset done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = (a >> $urandom_range(0, 31)) | 32'd1;
            endcase
            run_op(1'(i % 2), a, b, 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
